// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with a show-ahead frame FIFO.
// Define RX_MAJORITY_EN for 2-of-3 majority voting around mid-bit.
module uart_rx_param #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PAR_EN     = 1,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Bclkx16_,
  input  logic                          Rx,
  input  logic                          parity,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             data,
  output logic                          valid,
  output logic                          parity_error,
  output logic                          Rx_err,
  output logic                          Rx_done,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TW = $clog2(OVERSAMPLE) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 2;

  localparam logic [TW-1:0] BIT_T  = TW'(OVERSAMPLE);
`ifdef RX_MAJORITY_EN
  localparam logic [TW-1:0] START_T = TW'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [TW-1:0] START_T = TW'(OVERSAMPLE / 2);
`endif
  localparam logic [3:0]    LAST_D  = 4'(DATA_W - 1);
  localparam logic [3:0]    LAST_S  = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              r_state;
  logic                r_sync1;
  logic                r_rxs;
  logic [TW-1:0]       r_tick;
  logic [3:0]          r_bitn;
  logic [DATA_W-1:0]   r_shift;
  logic                r_perr;
  logic                r_ferr;
  logic                r_done;
  logic [EW-1:0]       r_ent;

  logic [EW-1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr;
  logic [AW-1:0]       r_rd;
  logic [CW-1:0]       r_count;
  logic                r_ovr;

  logic [TW-1:0]       w_tn;
  logic                w_bit;
  logic                w_pop;
  logic                w_full;
  logic                w_wr;
  logic [EW-1:0]       w_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= Rx;
      r_rxs   <= r_sync1;
    end
  end

`ifdef RX_MAJORITY_EN
  logic [1:0] r_hist;

  // Holds rxs from the two preceding ticks; the vote lands on the third.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= 2'b11;
    end else if (Bclkx16_) begin
      r_hist <= {r_hist[0], r_rxs};
    end
  end

  assign w_bit = (r_hist[1] & r_hist[0]) |
                 (r_hist[1] & r_rxs) |
                 (r_hist[0] & r_rxs);
`else
  assign w_bit = r_rxs;
`endif

  assign w_tn = r_tick + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
      r_ent   <= '0;
    end else begin
      r_done <= 1'b0;
      if (Bclkx16_) begin
        unique case (r_state)
          S_IDLE: begin
            if (!r_rxs) begin
              r_state <= S_START;
              r_tick  <= '0;
            end
          end
          S_START: begin
            if (w_tn == START_T) begin
              r_tick  <= '0;
              r_bitn  <= '0;
              r_perr  <= 1'b0;
              r_ferr  <= 1'b0;
              r_state <= w_bit ? S_IDLE : S_DATA;
            end else begin
              r_tick <= w_tn;
            end
          end
          S_DATA: begin
            if (w_tn == BIT_T) begin
              r_tick  <= '0;
              r_shift <= {w_bit, r_shift[DATA_W-1:1]};
              if (r_bitn == LAST_D) begin
                r_bitn  <= '0;
                r_state <= (PAR_EN != 0) ? S_PARITY : S_STOP;
              end else begin
                r_bitn <= r_bitn + 1'b1;
              end
            end else begin
              r_tick <= w_tn;
            end
          end
          S_PARITY: begin
            if (w_tn == BIT_T) begin
              r_tick  <= '0;
              r_perr  <= (^r_shift) ^ w_bit ^ parity;
              r_state <= S_STOP;
            end else begin
              r_tick <= w_tn;
            end
          end
          S_STOP: begin
            if (w_tn == BIT_T) begin
              r_tick <= '0;
              if (r_bitn == LAST_S) begin
                r_bitn  <= '0;
                r_done  <= 1'b1;
                r_ent   <= {r_shift, r_perr, r_ferr | ~w_bit};
                r_state <= S_IDLE;
              end else begin
                r_ferr <= r_ferr | ~w_bit;
                r_bitn <= r_bitn + 1'b1;
              end
            end else begin
              r_tick <= w_tn;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // The completed frame enters the FIFO the clk after Rx_done rises.
  assign w_pop  = rd_en && valid;
  assign w_full = (r_count == DEPTH_C);
  assign w_wr   = r_done && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= r_ent;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_pop) begin
        r_ovr <= 1'b0;
      end else if (r_done && w_full) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign w_head       = r_mem[r_rd];
  assign valid        = (r_count != '0);
  assign data         = valid ? w_head[EW-1:2] : '0;
  assign parity_error = valid & w_head[1];
  assign Rx_err       = valid & w_head[0];
  assign Rx_done      = r_done;
  assign overrun      = r_ovr;
  assign fifo_count   = r_count;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed scenarios plus random frames
// checked against a frame-level queue model.
module tb_uart_rx_param;

  localparam int DW = 8;
  localparam int OS = 16;
  localparam int PE = 1;
  localparam int SB = 1;
  localparam int FD = 4;
  localparam int CW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Bclkx16_ = 1'b0;
  logic          Rx = 1'b1;
  logic          parity = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data;
  logic          valid;
  logic          parity_error;
  logic          Rx_err;
  logic          Rx_done;
  logic          overrun;
  logic [CW-1:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic valid_at_done = 1'b0;
  logic valid_after_done = 1'b0;

  logic [DW+1:0] exp_q[$];
  logic          m_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .DATA_W(DW), .OVERSAMPLE(OS), .PAR_EN(PE),
    .STOP_BITS(SB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .Bclkx16_(Bclkx16_), .Rx(Rx),
    .parity(parity), .rd_en(rd_en), .data(data), .valid(valid),
    .parity_error(parity_error), .Rx_err(Rx_err),
    .Rx_done(Rx_done), .overrun(overrun), .fifo_count(fifo_count)
  );

  always @(negedge clk) begin
    if (prev_done) valid_after_done = valid;
    if (Rx_done) begin
      valid_at_done = valid;
      done_cnt++;
    end
    prev_done = Rx_done;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [DW+1:0] model(input logic [DW-1:0] d,
                                          input logic pb, input logic sb,
                                          input logic pm);
    int   ones;
    logic pe;
    ones = $countones(d) + (pb ? 1 : 0);
    pe   = (PE != 0) && ((ones % 2) != (pm ? 1 : 0));
    return {d, pe, ~sb};
  endfunction

  task automatic model_push(input logic [DW+1:0] e);
    if (exp_q.size() < FD) exp_q.push_back(e);
    else m_ovr = 1'b1;
  endtask

  task automatic model_pop();
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      m_ovr = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk) Bclkx16_ = 1'b1;
    @(negedge clk) Bclkx16_ = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    repeat (OS) tick();
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pb,
                            input logic sb);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (PE != 0) send_bit(pb);
    repeat (SB) send_bit(sb);
    Rx = 1'b1;
    repeat (20) tick();
  endtask

  task automatic pop();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({data, valid, parity_error, Rx_err, Rx_done, overrun, fifo_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b fe=%b done=%b ovr=%b cnt=%0d exp all 0",
               data, valid, parity_error, Rx_err, Rx_done, overrun, fifo_count);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL reset_release: got v=%b cnt=%0d exp 0/0", valid, fifo_count);
    end
  endtask

  task automatic test_basic();
    int n0;
    n0 = done_cnt;
    parity = 1'b0;
    valid_at_done = 1'b1;
    valid_after_done = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1);
    checks++;
    if (done_cnt !== n0 + 1) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses exp 1", done_cnt - n0);
    end
    checks++;
    if (valid_at_done !== 1'b0 || valid_after_done !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got valid %b/%b exp 0/1",
               valid_at_done, valid_after_done);
    end
    checks++;
    if ({data, parity_error, Rx_err} !== {8'hA5, 2'b00} || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL basic_entry: got %h pe=%b fe=%b cnt=%0d exp a5 0 0 1",
               data, parity_error, Rx_err, fifo_count);
    end
    pop();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pop: got valid=%b exp 0", valid);
    end
  endtask

  task automatic test_parity();
    parity = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1);
    checks++;
    if (data !== 8'hA5 || parity_error !== 1'b1) begin
      errors++;
      $display("FAIL parity_odd_bad: got %h pe=%b exp a5 1", data, parity_error);
    end
    pop();
    send_frame(8'hA5, 1'b1, 1'b1);
    checks++;
    if (data !== 8'hA5 || parity_error !== 1'b0) begin
      errors++;
      $display("FAIL parity_odd_good: got %h pe=%b exp a5 0", data, parity_error);
    end
    pop();
    parity = 1'b0;
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 1'b0);
    checks++;
    if ({data, parity_error, Rx_err} !== {8'h3C, 2'b01}) begin
      errors++;
      $display("FAIL framing_bad: got %h pe=%b fe=%b exp 3c 0 1",
               data, parity_error, Rx_err);
    end
    pop();
    send_frame(8'h55, 1'b0, 1'b1);
    checks++;
    if ({data, parity_error, Rx_err} !== {8'h55, 2'b00} || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL framing_next: got %h pe=%b fe=%b cnt=%0d exp 55 0 0 1",
               data, parity_error, Rx_err, fifo_count);
    end
    pop();
  endtask

  task automatic test_false_start();
    int n0;
    n0 = done_cnt;
    Rx = 1'b0;
    repeat (4) tick();
    Rx = 1'b1;
    repeat (40) tick();
    checks++;
    if (done_cnt !== n0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL false_start: got %0d pulses cnt=%0d exp 0 0",
               done_cnt - n0, fifo_count);
    end
  endtask

  task automatic test_overrun();
    int n0;
    logic [DW-1:0] d;
    n0 = done_cnt;
    for (int i = 1; i <= 5; i++) begin
      d = DW'(i);
      send_frame(d, ^d, 1'b1);
    end
    checks++;
    if (done_cnt !== n0 + 5) begin
      errors++;
      $display("FAIL overrun_done: got %0d pulses exp 5", done_cnt - n0);
    end
    checks++;
    if (fifo_count !== 3'd4 || overrun !== 1'b1 || data !== 8'h01) begin
      errors++;
      $display("FAIL overrun_full: got cnt=%0d ovr=%b head=%h exp 4 1 01",
               fifo_count, overrun, data);
    end
    for (int i = 1; i <= 4; i++) begin
      d = DW'(i);
      checks++;
      if (data !== d || valid !== 1'b1) begin
        errors++;
        $display("FAIL overrun_read%0d: got %h v=%b exp %h 1", i, data, valid, d);
      end
      pop();
      if (i == 1) begin
        checks++;
        if (overrun !== 1'b0) begin
          errors++;
          $display("FAIL overrun_clear: got %b exp 0", overrun);
        end
      end
    end
    checks++;
    if (valid !== 1'b0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL overrun_empty: got v=%b cnt=%0d exp 0 0", valid, fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h21, ^8'h21, 1'b1);
    send_frame(8'h42, ^8'h42, 1'b1);
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_fill: got cnt=%0d exp 2", fifo_count);
    end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    Rx = 1'b0;
    repeat (5) tick();
    @(negedge clk) rst = 1'b0;
    #1;
    checks++;
    if ({data, valid, parity_error, Rx_err, Rx_done, overrun, fifo_count} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got data=%h v=%b cnt=%0d exp 0",
               data, valid, fifo_count);
    end
    Rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) tick();
    send_frame(8'h12, ^8'h12, 1'b1);
    checks++;
    if ({data, parity_error, Rx_err} !== {8'h12, 2'b00} || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_after: got %h pe=%b fe=%b cnt=%0d exp 12 0 0 1",
               data, parity_error, Rx_err, fifo_count);
    end
    pop();
  endtask

  task automatic test_random();
    int n0;
    int npop;
    logic [DW-1:0] d;
    logic pb;
    logic sb;
    logic pm;
    exp_q.delete();
    m_ovr = 1'b0;
    n0 = done_cnt;
    for (int f = 0; f < 24; f++) begin
      d  = DW'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      pm = 1'($urandom);
      parity = pm;
      send_frame(d, pb, sb);
      model_push(model(d, pb, sb, pm));
      checks++;
      if (fifo_count !== CW'(exp_q.size()) || overrun !== m_ovr) begin
        errors++;
        $display("FAIL rand%0d_state: got cnt=%0d ovr=%b exp %0d %b",
                 f, fifo_count, overrun, exp_q.size(), m_ovr);
      end
      checks++;
      if ({data, parity_error, Rx_err} !== exp_q[0]) begin
        errors++;
        $display("FAIL rand%0d_head: got %h %b %b exp %h", f,
                 data, parity_error, Rx_err, exp_q[0]);
      end
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) begin
        pop();
        model_pop();
        checks++;
        if (valid !== (exp_q.size() > 0) || overrun !== m_ovr) begin
          errors++;
          $display("FAIL rand%0d_pop%0d: got v=%b ovr=%b exp %b %b", f, k,
                   valid, overrun, exp_q.size() > 0, m_ovr);
        end
      end
    end
    while (exp_q.size() > 0) begin
      checks++;
      if ({data, parity_error, Rx_err} !== exp_q[0]) begin
        errors++;
        $display("FAIL rand_drain: got %h %b %b exp %h",
                 data, parity_error, Rx_err, exp_q[0]);
      end
      pop();
      model_pop();
    end
    checks++;
    if (done_cnt !== n0 + 24 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_total: got %0d pulses v=%b exp 24 0",
               done_cnt - n0, valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_false_start();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8-bit receiver grand-module. It is a single-clock UART receive path with configurable data width, oversampling ratio, parity and stop bits. Each frame is stored with its error flags in a small show-ahead FIFO so that bursts survive a slow consumer. It sits between the serial Rx pin and the host-side consumer, and is driven by the shared Bclkx16_ baud-tick enable.

Parameters:
DATA_W, 8, data bits per frame (legal 5..9)
OVERSAMPLE, 16, Bclkx16_ ticks per bit period (even, 8..32)
PAR_EN, 1, 1 = parity bit present after data, 0 = no parity bit
STOP_BITS, 1, stop bits checked (1 or 2)
FIFO_DEPTH, 4, frame FIFO entries (power of two, 2..16)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
Bclkx16_  input  1  one-clk-wide baud tick enable, OVERSAMPLE ticks per bit
Rx  input  1  serial input, idle high
parity  input  1  parity mode: 0 = even, 1 = odd (ignored if PAR_EN=0)
rd_en  input  1  pop head entry; ignored when valid=0
data  output  DATA_W  head entry data, LSB = first bit received
valid  output  1  FIFO not empty
parity_error  output  1  head entry parity flag
Rx_err  output  1  head entry framing flag (a stop bit sampled low)
Rx_done  output  1  one-clk pulse, asserted when a frame completes
overrun  output  1  sticky flag: a frame was dropped because the FIFO was full
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored entries

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counters, FIFO pointers and synchronizer cleared, synchronizer flops reset to 1.
  - data=0, valid=0, parity_error=0, Rx_err=0, Rx_done=0, overrun=0, fifo_count=0.
- Input sync: Rx passes through a 2-flop synchronizer. All decisions use the synchronized value rxs.
- Tick counter: advances only on cycles with Bclkx16_=1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rxs=0 on a tick, go to START with tick count cleared.
  - START: at tick OVERSAMPLE/2 (mid-bit), sample rxs.
    - rxs=1: false start, return to IDLE, nothing recorded.
    - rxs=0: clear count and go to DATA.
  - DATA: sample every OVERSAMPLE ticks, shifting LSB first. After DATA_W samples, go to PARITY if PAR_EN=1, else go to STOP.
  - PARITY: sample one bit. perr = XOR(data bits, sampled bit, parity). Even mode requires the total count of ones to be even.
  - STOP: sample STOP_BITS bits. ferr=1 if any sampled stop bit is 0.
  - After the last stop sample: push {data, perr, ferr}, pulse Rx_done for one clk, return to IDLE. The next frame's falling edge is accepted on the next tick.
- Frames with ferr or perr are still pushed; the flags travel with the entry.
- FIFO (show-ahead):
  - data, parity_error and Rx_err always reflect the head entry, and are 0 when empty.
  - A pushed entry is visible the clk after the push (valid rises 1 clk after Rx_done).
  - Pop on rd_en && valid; the next entry is visible the following clk.
- Simultaneous pop and push, including when full: both performed, fifo_count unchanged.
- Push when full with no pop: frame dropped, overrun=1 (sticky), Rx_done still pulses.
- overrun clears on the first accepted pop.
- Pointers wrap modulo FIFO_DEPTH.
- rd_en on empty: no effect.
- Reset mid-frame: frame discarded, FIFO emptied, FSM restarts in IDLE.
- Bclkx16_ low: the FSM holds state; the FIFO still serves reads.

Optional Feature:
RX_MAJORITY_EN
- Defined: every bit sample (start, data, parity, stop) is the 2-of-3 majority of rxs at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, and the decision is made at tick OVERSAMPLE/2+1. A single-tick glitch at mid-bit is rejected.
- Undefined: single sample at tick OVERSAMPLE/2, and the majority logic is not synthesized.

Test Plan:
- Default params, parity=0: frame 0xA5 with parity bit 0 and stop 1 -> Rx_done pulse; next clk valid=1, data=0xA5, parity_error=0, Rx_err=0, fifo_count=1; rd_en -> valid=0.
- parity=1, same frame 0xA5 with parity bit 0 -> data=0xA5, parity_error=1. Repeat with parity bit 1 -> parity_error=0.
- Frame 0x3C with stop bit driven 0 -> data=0x3C, Rx_err=1. The next good frame 0x55 is received correctly.
- Rx low for only 4 ticks, then high -> no Rx_done, fifo_count stays 0.
- FIFO_DEPTH=4, send 0x01..0x05 with no reads:
  - fifo_count=4, overrun=1, head=0x01.
  - Reads return 0x01..0x04 (0x05 dropped); overrun clears on the first pop.
- rst=0 mid-DATA of frame 0x77 after two entries are stored -> all outputs 0 immediately. After release, frame 0x12 -> data=0x12, fifo_count=1.
